// File: rtl/align_shifter_pipe_pkg.sv
// align_shifter_pipe_pkg: default widths, per-stage shift-bit slicing and the stage payload layout
package align_shifter_pipe_pkg;
  localparam int IN_W_DEF = 26;
  localparam int OUT_W_DEF = 50;
  localparam int SH_W_DEF = 8;
  localparam int STAGES_DEF = 2;
  typedef struct packed {
    int lo;
    int hi;
  } slice_t;
  typedef struct packed {
    logic [OUT_W_DEF-1:0] data;
    logic [SH_W_DEF-1:0]  rem_shift;
    logic                 fill;
    logic                 sticky;
    logic                 zero;
  } payload_t;
  function automatic slice_t stage_bits(input int stage, input int sh_w, input int stages);
    int per;
    slice_t r;
    per = (sh_w + stages - 1) / stages;
    r.lo = stage * per;
    r.hi = (r.lo + per > sh_w ? sh_w : r.lo + per) - 1;
    return r;
  endfunction
endpackage

// File: rtl/align_shift_stage.sv
// align_shift_stage: one elastic register stage applying shift bits LO..HI (ports: in_*/out_* valid/ready + data, rem, fill, sticky, zero)
module align_shift_stage
  import align_shifter_pipe_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int SH_W  = SH_W_DEF,
  parameter int LO    = 0,
  parameter int HI    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  input  logic [SH_W-1:0]  in_rem,
  input  logic             in_fill,
  input  logic             in_sticky,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [SH_W-1:0]  out_rem,
  output logic             out_fill,
  output logic             out_sticky,
  output logic             out_zero
);
  localparam logic [OUT_W-1:0] ONES = '1;
  logic [OUT_W-1:0] d;
  logic [SH_W-1:0]  rem;
  logic             st;
  // sub-shifts of 2^k >= OUT_W flush the whole field into sticky
  always_comb begin
    d = in_data;
    st = in_sticky;
    rem = in_rem;
    for (int k = LO; k <= HI; k++) begin
      if (in_rem[k]) begin
        if ((1 << k) >= OUT_W) begin
          st = st | (|d);
          d = {OUT_W{in_fill}};
        end else begin
          st = st | (|(d & ~(ONES << (1 << k))));
          d = (d >> (1 << k)) | (in_fill ? ~(ONES >> (1 << k)) : '0);
        end
        rem[k] = 1'b0;
      end
    end
  end
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else if (in_ready) out_valid <= in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_rem <= '0;
      out_fill <= 1'b0;
      out_sticky <= 1'b0;
      out_zero <= 1'b0;
    end else if (in_ready && in_valid) begin
      out_data <= d;
      out_rem <= rem;
      out_fill <= in_fill;
      out_sticky <= st;
      out_zero <= in_zero;
    end
  end
endmodule

// File: rtl/align_shifter_pipe.sv
// align_shifter_pipe: pipelined right-align shifter with fill, sticky and zero (ports: in_valid/in_ready/in_data/in_shift/in_sig, out_valid/out_ready/out_data/out_sticky/out_zero)
module align_shifter_pipe
  import align_shifter_pipe_pkg::*;
#(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SH_W   = SH_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [SH_W-1:0]  in_shift,
  input  logic             in_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sticky,
  output logic             out_zero
);
  logic             v   [0:STAGES];
  logic             r   [0:STAGES];
  logic [OUT_W-1:0] d   [0:STAGES];
  logic [SH_W-1:0]  rem [0:STAGES];
  logic             f   [0:STAGES];
  logic             st  [0:STAGES];
  logic             z   [0:STAGES];
  assign v[0] = in_valid;
  assign in_ready = r[0];
  assign d[0] = OUT_W'(in_data) << (OUT_W - IN_W);
  assign rem[0] = in_shift;
  assign f[0] = in_sig & (|in_data);
  assign st[0] = 1'b0;
  assign z[0] = ~|in_data;
  assign r[STAGES] = out_ready;
  assign out_valid = v[STAGES];
  assign out_data = d[STAGES];
  assign out_sticky = st[STAGES];
  assign out_zero = z[STAGES];
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam slice_t B = stage_bits(s, SH_W, STAGES);
    align_shift_stage #(
      .OUT_W(OUT_W),
      .SH_W (SH_W),
      .LO   (B.lo),
      .HI   (B.hi)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v[s]),
      .in_ready  (r[s]),
      .in_data   (d[s]),
      .in_rem    (rem[s]),
      .in_fill   (f[s]),
      .in_sticky (st[s]),
      .in_zero   (z[s]),
      .out_valid (v[s+1]),
      .out_ready (r[s+1]),
      .out_data  (d[s+1]),
      .out_rem   (rem[s+1]),
      .out_fill  (f[s+1]),
      .out_sticky(st[s+1]),
      .out_zero  (z[s+1])
    );
  end
endmodule

// File: tb/tb_align_shifter_pipe.sv
// tb_align_shifter_pipe: randomized scoreboard bench for align_shifter_pipe with directed boundary, stall and reset cases
module tb_align_shifter_pipe;
  localparam int IN_W = 26, OUT_W = 50, SH_W = 8, STAGES = 2;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_sig = 0, out_ready = 1;
  logic in_ready, out_valid, out_sticky, out_zero;
  logic [IN_W-1:0] in_data = '0;
  logic [SH_W-1:0] in_shift = '0;
  logic [OUT_W-1:0] out_data;
  typedef struct {
    logic [OUT_W-1:0] d;
    logic s;
    logic z;
    int c;
  } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0, cyc = 0;
  bit lat_exact = 0, stalled = 0, saw_drop = 0;
  logic [OUT_W+1:0] held;

  align_shifter_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shift(in_shift), .in_sig(in_sig), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sticky(out_sticky), .out_zero(out_zero));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference: whole-field arithmetic shift, result packed as {data, sticky, zero}
  function automatic logic [OUT_W+1:0] model(input logic [IN_W-1:0] d, input logic [SH_W-1:0] sh, input logic sg);
    logic [OUT_W-1:0] ext, ones, res;
    logic f, stk;
    ext = OUT_W'(d) << (OUT_W - IN_W);
    ones = '1;
    f = (d != 0) && sg;
    if (int'(sh) >= OUT_W) return {{OUT_W{f}}, d != 0, d == 0};
    res = (ext >> sh) | (f ? ~(ones >> sh) : '0);
    stk = |(ext & ~(ones << sh));
    return {res, stk, d == 0};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [OUT_W+1:0] m;
    if (!rst_n) stalled = 0;
    else begin
      if (stalled) check("stable", {out_valid, out_data, out_sticky, out_zero}, {1'b1, held});
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out", out_valid, 0);
        else if (out_ready) begin
          e = q.pop_front();
          check("data", out_data, e.d);
          check("sticky", out_sticky, e.s);
          check("zero", out_zero, e.z);
          if (lat_exact) check("latency", cyc - e.c, STAGES);
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_data, out_sticky, out_zero};
      if (in_valid && !in_ready) saw_drop = 1;
      if (in_valid && in_ready) begin
        m = model(in_data, in_shift, in_sig);
        e.d = m[OUT_W+1:2];
        e.s = m[1];
        e.z = m[0];
        e.c = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] d, input logic [SH_W-1:0] sh, input logic sg);
    in_valid = 1;
    in_data = d;
    in_shift = sh;
    in_sig = sg;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 0;
    out_ready = 1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    int i, sent;
    bit acc;
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int i, sent;
    bit acc;
    // model pinned to hand-computed values
    check("pin_shift0", model(26'h2000000, 0, 0), {50'h2_0000_0000_0000, 2'b00});
    check("pin_shift4", model(26'h3FFFFFF, 4, 1), {50'h3_FFFF_FFF0_0000, 2'b00});
    check("pin_s24", model(26'h1, 24, 0), {50'h1, 2'b00});
    check("pin_s25", model(26'h1, 25, 0), {50'h0, 2'b10});
    check("pin_zero", model(26'h0, 60, 1), {50'h0, 2'b01});
    check("pin_sat", model(26'h1, 200, 1), {50'h3_FFFF_FFFF_FFFF, 2'b10});
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;
    lat_exact = 1;
    send(26'h2000000, 0, 0);
    send(26'h3FFFFFF, 4, 1);
    send(26'h1, 24, 0);
    send(26'h1, 25, 0);
    send(26'h0, 60, 1);
    send(26'h1, 200, 1);
    send(26'h155AAAA, 26, 1);
    send(26'h0FFFFFF, 49, 1);
    send(26'h0FFFFFF, 50, 0);
    drain();
    lat_exact = 0;
    // back-pressure: 8 back-to-back, out_ready low on cycles 3..6
    saw_drop = 0;
    sent = 0;
    i = 0;
    while (sent < 8 && i < 100) begin
      out_ready = !(i >= 3 && i <= 6);
      in_valid = 1;
      in_data = IN_W'($urandom);
      in_shift = SH_W'($urandom_range(0, 60));
      in_sig = 1'($urandom);
      #1;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      i++;
    end
    check("bp_sent", sent, 8);
    check("bp_in_ready_drop", saw_drop, 1);
    drain();
    // reset with two transactions in flight
    out_ready = 0;
    in_valid = 1;
    in_data = 26'h1234567;
    in_shift = 3;
    @(posedge clk); #1;
    in_data = 26'h0ABCDEF;
    @(posedge clk); #1;
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 0;
    q.delete();
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_sticky", out_sticky, 0);
    check("async_rst_in_ready", in_ready, 1);
    @(negedge clk); #2;
    rst_n = 1;
    out_ready = 1;
    repeat (6) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end
    send(26'h0000F0F, 7, 1);
    drain();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 4))
        0: in_data = '0;
        1: in_data = 26'h1;
        default: in_data = IN_W'($urandom);
      endcase
      in_shift = ($urandom_range(0, 1) != 0) ? SH_W'($urandom_range(0, 60)) : SH_W'($urandom);
      in_sig = 1'($urandom);
      @(posedge clk); #1;
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/align_shifter_pipe.md
# align_shifter_pipe

Parametrised, pipelined mantissa alignment shifter for the floating-point preparer datapath. It right-aligns an input mantissa into a wider output field by a variable amount and fills vacated upper bits with the sign-fill bit. It also produces a sticky bit for bits shifted past bit 0 and a zero flag. It sits between exponent-difference logic and the adder, with a valid/ready handshake on both sides and full one-per-cycle throughput.

## Interface
Parameters:
- IN_W, 26, input mantissa width
- OUT_W, 50, output field width; must satisfy OUT_W ≥ IN_W
- SH_W, 8, shift-amount width
- STAGES, 2, register stages (1..SH_W); equals latency in cycles

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  IN_W  mantissa
- in_shift  in  SH_W  right-shift amount, unsigned
- in_sig  in  1  sign-fill bit
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  aligned result
- out_sticky  out  1  OR of all bits shifted below bit 0
- out_zero  out  1  in_data was zero

## Operation
- ext = {in_data, (OUT_W−IN_W) zeros}, so the input MSB lands at bit OUT_W−1.
- Fill bit f = in_sig if in_data ≠ 0, else 0.
- Output bit i = f when i > OUT_W−1−shift; otherwise it is (ext >> shift)[i].
- shift ≥ OUT_W: out_data is all f; out_sticky = |in_data.
- out_sticky = OR of ext[shift−1:0] for shift ≤ OUT_W. It can be 1 only when shift > OUT_W−IN_W.
- out_zero = (in_data == 0). It travels with the transaction.
- Decomposition:
  - The shift is split into SH_W binary sub-shifts by 2^k, LSB first.
  - These are grouped into STAGES contiguous slices of ceil(SH_W/STAGES) bits each; the last stage takes the remainder.
  - Each sub-shift inserts f at the top and ORs the dropped bits into a running sticky.
  - A sub-shift with 2^k ≥ OUT_W saturates: data becomes all f, and sticky |= |data.
- Each stage register holds: valid, partial data, the remaining shift bits, f, sticky and zero.

## Timing
- Latency is exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid with no stall.
- Throughput is one transaction per cycle when out_ready is held high.
- Elastic pipeline:
  - A stage loads when it is empty or its contents advance the same cycle.
  - in_ready = stage 0 can load.
  - A combinational path out_ready→in_ready is permitted.
- Transfer occurs only when valid && ready are both high. Payload is held stable while out_valid && !out_ready.
- in_valid may toggle freely. Data presented while in_ready=0 is ignored.
- Order is preserved; no loss or duplication under any stall pattern.
- Simultaneous accept and emit with the pipeline full: both occur and occupancy is unchanged.
- Reset:
  - All stage valids, out_valid, out_data, out_sticky and out_zero go to 0 asynchronously.
  - in_ready is 1 after reset.
  - In-flight transactions are discarded. Nothing is emitted after release until new input is accepted.

## Structure
- Shared package holds:
  - default widths
  - function stage_bits(stage) → slice low/high shift-bit indices
  - the per-stage payload struct (data, rem_shift, fill, sticky, zero)
- Sub-module align_shift_stage:
  - one register stage applying one slice of sub-shifts
  - has its own valid/ready
  - the top level instantiates STAGES of them in a generate chain

## Test plan
Defaults apply (IN_W=26, OUT_W=50).
- in_data=26'h2000000, shift=0, sig=0 → out_data=50'h2_0000_0000_0000, sticky=0, zero=0, after exactly 2 cycles.
- in_data=26'h3FFFFFF, shift=4, sig=1 → out_data=50'h3_FFFF_FFF0_0000, sticky=0.
- Sticky boundary, in_data=26'h0000001, sig=0:
  - shift=24 → out_data=50'h1, sticky=0.
  - shift=25 → out_data=0, sticky=1.
- Saturation and zero:
  - in_data=0, shift=60, sig=1 → out_data=0, sticky=0, zero=1.
  - in_data=1, shift=200, sig=1 → out_data=50'h3_FFFF_FFFF_FFFF, sticky=1.
- Back-pressure: 8 back-to-back inputs with random shifts, out_ready low on cycles 3–6 → in_ready drops once the 2 stages are full. All 8 results are emitted in order, match the reference model, and are stable while stalled.
- Reset mid-flight: assert rst_n=0 with 2 transactions in flight → out_valid=0 immediately without a clock edge; no output after release until new input arrives.
